// File: rtl/alu32_arbiter.sv
// Purpose: shares one external combinational 32-bit ALU between NREQ requesters, round-robin.
// Latency: grant in cycle 0, ALU evaluated in cycle 1, registered response valid from cycle 2.
// Backpressure: response is held until resp_ready; no new grant is issued while a response is pending.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   req_valid/req_ready        per-requester request / one-hot grant (combinational)
//   req_a/req_b/req_op         packed per-requester operands ([32*i+:32]) and op ([2*i+:2])
//   alu_a/alu_b/alu_ctrl       registered operands driven to the shared ALU
//   alu_result/alu_flags       combinational ALU outputs {neg, zero, carry, overflow}
//   resp_valid/resp_ready      response handshake
//   resp_id/result/flags       registered response payload
//   busy                       high whenever an operation is in flight
module alu32_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ*2-1:0]    req_op,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [1:0]           alu_ctrl,
  input  logic [31:0]          alu_result,
  input  logic [3:0]           alu_flags,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_result,
  output logic [3:0]           resp_flags,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] rr_nxt;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] gnt_sel;
  logic           gnt_found;
  logic [IDW:0]   scan_idx;
  logic [31:0]    op_a;
  logic [31:0]    op_b;
  logic [1:0]     op_ctrl;
  logic [31:0]    sel_a;
  logic [31:0]    sel_b;
  logic [1:0]     sel_op;

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping at NREQ.
  // scan_idx carries one extra bit so the wrap works for non-power-of-two NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_sel   = rr_ptr;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan_idx >= (IDW+1)'(NREQ)) begin
        scan_idx = scan_idx - (IDW+1)'(NREQ);
      end
      if (!gnt_found && req_valid[scan_idx[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_sel   = scan_idx[IDW-1:0];
      end
    end
  end

  assign rr_nxt = (gnt_sel == IDW'(NREQ - 1)) ? '0 : gnt_sel + 1'b1;

  // Operand select for the winning requester.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_sel == IDW'(i)) begin
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
        sel_op = req_op[2*i +: 2];
      end
    end
  end

  // Next state and grant. The grant is masked during reset so no requester
  // believes it was accepted on an edge where the FSM is being cleared.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          state_d            = EXEC;
          req_ready[gnt_sel] = !reset;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr      <= '0;
      gnt_id      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_ctrl     <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_flags  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && gnt_found) begin
        op_a    <= sel_a;
        op_b    <= sel_b;
        op_ctrl <= sel_op;
        gnt_id  <= gnt_sel;
        rr_ptr  <= rr_nxt;
      end
      if (state_q == EXEC) begin
        resp_result <= alu_result;
        resp_flags  <= alu_flags;
        resp_id     <= gnt_id;
        resp_valid  <= 1'b1;
      end
      if (state_q == RESP && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  // ALU inputs come straight from the capture registers, so they only move on a grant.
  assign alu_a    = op_a;
  assign alu_b    = op_b;
  assign alu_ctrl = op_ctrl;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu32_arbiter.sv
// Purpose: randomized and directed bench for alu32_arbiter with an ALU stub and a scoreboard.
// Latency: responses expected two cycles after each grant.
// Backpressure: resp_ready is randomly withheld; stalls are checked for stable outputs.
module tb_alu32_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ*2-1:0] req_op;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [1:0]        alu_ctrl;
  logic [31:0]       alu_result;
  logic [3:0]        alu_flags;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [31:0]       resp_result;
  logic [3:0]        resp_flags;
  logic              busy;

  always #5 clk = ~clk;

  alu32_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .resp_flags(resp_flags),
    .busy(busy)
  );

  // Combinational ALU stub, bit-level formulation.
  logic [32:0] alu_t;
  logic        alu_c;
  logic        alu_v;
  always_comb begin
    alu_t = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_ctrl)
      2'b00: begin
        alu_t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c = alu_t[32];
        alu_v = (alu_a[31] == alu_b[31]) && (alu_t[31] != alu_a[31]);
      end
      2'b01: begin
        alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_c = alu_t[32];
        alu_v = (alu_a[31] != alu_b[31]) && (alu_t[31] != alu_a[31]);
      end
      2'b10:   alu_t = {1'b0, alu_a & alu_b};
      default: alu_t = {1'b0, alu_a | alu_b};
    endcase
    alu_result = alu_t[31:0];
    alu_flags  = {alu_t[31], (alu_t[31:0] == 32'd0), alu_c, alu_v};
  end

  // Reference: integer arithmetic, returns {flags, result}.
  function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s  = 0;
    logic [31:0] r;
    logic c = 1'b0;
    logic v = 1'b0;
    case (op)
      2'b00: begin r = a + b; c = (ua + ub) > 64'hFFFF_FFFF; s = sa + sb; v = (s > MAXS) || (s < MINS); end
      2'b01: begin r = a - b; c = (ua >= ub); s = sa - sb; v = (s > MAXS) || (s < MINS); end
      2'b10: r = a & b;
      default: r = a | b;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  // Round-robin choice from the rules: first valid at rr, rr+1, ... mod NREQ.
  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] res;
    logic [3:0]  fl;
    int          gcyc;
  } exp_t;

  exp_t            exp_q[$];
  int              resp_log[$];
  int              errors = 0;
  int              checks = 0;
  int              cyc = 0;
  int              m_rr = 0;
  int              last_grant = -1;
  int              mg;
  bit              exp_gap3 = 1'b0;
  bit              head_seen = 1'b0;
  logic [NREQ-1:0] gnt_seen = '0;
  exp_t            e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor / scoreboard, samples on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      m_rr       = 0;
      last_grant = -1;
      head_seen  = 1'b0;
      gnt_seen   = '0;
    end else begin
      if (req_ready != '0) begin
        mg = pick(req_valid, m_rr);
        chk("grant_onehot", {60'd0, req_ready}, (mg < 0) ? 64'd0 : (64'd1 << mg));
        if (last_grant >= 0) begin
          if (exp_gap3) begin
            chk("grant_gap", 64'(cyc - last_grant), 64'd3);
          end else begin
            checks++;
            if (cyc - last_grant < 3) begin
              errors++;
              $display("FAIL grant_gap_min: got %0d cycles required >=3", cyc - last_grant);
            end
          end
        end
        gnt_seen = gnt_seen | req_ready;
        if (mg >= 0) begin
          e.id   = mg;
          e.a    = req_a[32*mg +: 32];
          {e.fl, e.res} = ref_alu(e.a, req_b[32*mg +: 32], req_op[2*mg +: 2]);
          e.gcyc = cyc;
          exp_q.push_back(e);
          m_rr       = (mg + 1) % NREQ;
          last_grant = cyc;
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got id %0d result %0h with nothing outstanding", resp_id, resp_result);
        end else begin
          e = exp_q[0];
          if (!head_seen) begin
            chk("resp_latency", 64'(cyc - e.gcyc), 64'd2);
            head_seen = 1'b1;
          end
          chk("resp_id", 64'(resp_id), 64'(e.id));
          chk("resp_result", 64'(resp_result), 64'(e.res));
          chk("resp_flags", 64'(resp_flags), 64'(e.fl));
          chk("alu_a_hold", 64'(alu_a), 64'(e.a));
          chk("resp_no_grant", 64'(req_ready), 64'd0);
          chk("resp_busy", 64'(busy), 64'd1);
          if (resp_ready) begin
            void'(exp_q.pop_front());
            head_seen = 1'b0;
            resp_log.push_back(e.id);
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[2*i +: 2]  = op;
    req_valid[i]      = 1'b1;
  endtask

  task automatic new_req(input int i);
    logic [31:0] a = $urandom;
    logic [31:0] b = $urandom;
    case ($urandom_range(7))
      0: b = a;
      1: a = 32'h8000_0000;
      2: b = 32'hFFFF_FFFF;
      default: ;
    endcase
    set_req(i, a, b, 2'($urandom_range(3)));
  endtask

  // One call = n clock cycles. Granted requesters drop (or re-issue when cont).
  task automatic drive(input int n, input bit cont, input int p_new, input int p_rdy);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_seen[i]) begin
          gnt_seen[i]  = 1'b0;
          req_valid[i] = 1'b0;
          if (cont) new_req(i);
        end else if (!req_valid[i] && int'($urandom_range(99)) < p_new) begin
          new_req(i);
        end
      end
      resp_ready = (int'($urandom_range(99)) < p_rdy);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((req_valid != '0 || busy || exp_q.size() != 0) && t < 200) begin
      drive(1, 1'b0, 0, 100);
      t++;
    end
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding after %0d cycles required 0", exp_q.size(), t);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_resp_id"}, 64'(resp_id), 64'd0);
    chk({tag, "_resp_result"}, 64'(resp_result), 64'd0);
    chk({tag, "_resp_flags"}, 64'(resp_flags), 64'd0);
    chk({tag, "_alu_a"}, 64'(alu_a), 64'd0);
    chk({tag, "_alu_b"}, 64'(alu_b), 64'd0);
    chk({tag, "_alu_ctrl"}, 64'(alu_ctrl), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_valid = '0;
    gnt_seen  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic directed(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] er, input logic [3:0] ef);
    int t = 0;
    @(posedge clk);
    #1;
    set_req(id, a, b, op);
    resp_ready = 1'b1;
    while (!resp_valid && t < 20) begin
      drive(1, 1'b0, 0, 100);
      t++;
    end
    if (!resp_valid) begin
      checks++;
      errors++;
      $display("FAIL dir_timeout: got no response for requester %0d required one", id);
    end else begin
      chk("dir_id", 64'(resp_id), 64'(id));
      chk("dir_result", 64'(resp_result), 64'(er));
      chk("dir_flags", 64'(resp_flags), 64'(ef));
    end
    drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int t;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    reset      = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Directed arithmetic cases.
    directed(0, 32'd5, 32'd3, 2'b00, 32'd8, 4'b0000);
    directed(2, 32'd3, 32'd5, 2'b01, 32'hFFFF_FFFE, 4'b1000);
    directed(2, 32'd5, 32'd5, 2'b01, 32'd0, 4'b0110);
    directed(1, 32'h7FFF_FFFF, 32'd1, 2'b00, 32'h8000_0000, 4'b1001);
    directed(1, 32'hF0F0_0000, 32'h0F0F_0000, 2'b10, 32'd0, 4'b0100);

    // All requesters saturated from rr_ptr 0: ids 0,1,2,3,0 at one grant per 3 cycles.
    do_reset();
    resp_log.delete();
    for (int i = 0; i < NREQ; i++) new_req(i);
    exp_gap3 = 1'b1;
    drive(16, 1'b1, 0, 100);
    exp_gap3 = 1'b0;
    drain();
    chk("sat_count_ge5", 64'(resp_log.size() >= 5), 64'd1);
    for (int k = 0; k < 5 && k < resp_log.size(); k++) begin
      chk("sat_id_seq", 64'(resp_log[k]), 64'(exp_seq[k]));
    end

    // Response stall with everyone else requesting.
    for (int i = 0; i < NREQ; i++) new_req(i);
    drive(10, 1'b0, 0, 0);
    @(negedge clk);
    chk("stall_resp_valid", 64'(resp_valid), 64'd1);
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_req_ready", 64'(req_ready), 64'd0);
    drain();

    // Random traffic with random backpressure.
    drive(400, 1'b0, 35, 70);
    drain();

    // Reset while an op is in EXEC, requester 3 pending.
    @(posedge clk);
    #1;
    req_valid = '0;
    new_req(0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready[0] && t < 10);
    chk("mid_grant0", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    gnt_seen  = '0;
    new_req(3);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("midrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_grant3", 64'(req_ready), 64'b1000);
    chk("post_rst_no_resp", 64'(resp_valid), 64'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
